// File: rtl/roi_window_ctrl_if.sv
// Command and statistics handshakes between the ROI window controller and its host.
// The master is the host side; the slave is roi_window_ctrl.
interface roi_window_ctrl_if;
    logic       CMD_VALID;
    logic [2:0] CMD_OP;
    logic       CMD_READY;
    logic       STAT_REQ;
    logic       STAT_ACK;
    logic       STAT_OVF;

    modport master (
        output CMD_VALID, CMD_OP, STAT_ACK,
        input  CMD_READY, STAT_REQ, STAT_OVF
    );

    modport slave (
        input  CMD_VALID, CMD_OP, STAT_ACK,
        output CMD_READY, STAT_REQ, STAT_OVF
    );
endinterface

// File: rtl/roi_window_ctrl.sv
// Frame-synchronous ROI window controller: measures the active frame, applies move/resize
// commands at frame start, flags in-window/border pixels and schedules statistics passes.
module roi_window_ctrl #(
    parameter logic [15:0] STEP     = 16'd8,
    parameter logic [15:0] MIN_SIZE = 16'd16,
    parameter logic [15:0] INIT_W   = 16'd200,
    parameter logic [15:0] INIT_H   = 16'd200,
    parameter logic [7:0]  STAT_DIV = 8'd4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VS,
    input  logic             HS,
    input  logic             DE,
    roi_window_ctrl_if.slave cmd,
    output logic [15:0]      WIN_X0,
    output logic [15:0]      WIN_Y0,
    output logic [15:0]      WIN_W,
    output logic [15:0]      WIN_H,
    output logic [15:0]      FRM_W,
    output logic [15:0]      FRM_H,
    output logic             WIN_VALID,
    output logic             IN_WIN,
    output logic             BORDER
);
    localparam logic [16:0] STEP2 = {STEP, 1'b0};

    typedef enum logic [1:0] {StInit, StMeas, StRun} state_e;

    function automatic logic [15:0] pos_dec(input logic [15:0] p);
        return (p >= STEP) ? p - STEP : 16'd0;
    endfunction

    function automatic logic [15:0] pos_inc(input logic [15:0] p, input logic [15:0] s,
                                            input logic [15:0] f);
        logic [15:0] lim;
        logic [16:0] sum;
        lim = f - s;
        sum = {1'b0, p} + {1'b0, STEP};
        return (sum > {1'b0, lim}) ? lim : sum[15:0];
    endfunction

    function automatic logic [15:0] size_grow(input logic [15:0] s, input logic [15:0] f);
        logic [16:0] sum;
        sum = {1'b0, s} + STEP2;
        return (sum > {1'b0, f}) ? f : sum[15:0];
    endfunction

    function automatic logic [15:0] pos_fit(input logic [15:0] p, input logic [15:0] s,
                                            input logic [15:0] f);
        logic [16:0] sum;
        sum = {1'b0, p} + {1'b0, s};
        return (sum > {1'b0, f}) ? f - s : p;
    endfunction

    function automatic logic [15:0] size_shrink(input logic [15:0] s);
        return ({1'b0, s} >= ({1'b0, MIN_SIZE} + STEP2)) ? s - STEP2[15:0] : MIN_SIZE;
    endfunction

    state_e      state_q, state_d;
    logic        vs_q, hs_q, fs, ls;
    logic [15:0] x_q, y_q, lw_q, x_cur, y_cur, meas_w, meas_h;
    logic        line_de_q;
    logic [15:0] x0_q, y0_q, w_q, h_q, frm_w_q, frm_h_q;
    logic [15:0] x0_d, y0_d, w_d, h_d, frm_w_d, frm_h_d;
    logic        valid_q, valid_d, pend_q, pend_d;
    logic [15:0] px0_q, py0_q, pw_q, ph_q, px0_d, py0_d, pw_d, ph_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        req_q, req_d, ovf_q, ovf_d, in_q, in_d, border_q, border_d;
    logic        ready, accept;
    logic [15:0] init_w, init_h, gw, gh, sw, sh;
    logic [16:0] x_end, y_end;

    // Edge detectors keep tracking through reset so a release mid-frame sees no false FS.
    always_ff @(posedge CLK) begin
        vs_q <= VS;
        hs_q <= HS;
    end

    assign fs     = VS & ~vs_q;
    assign ls     = HS & ~hs_q & VS;
    assign x_cur  = ls ? 16'd0 : x_q;
    assign y_cur  = ls ? y_q + {15'd0, line_de_q} : y_q;
    assign meas_w = line_de_q ? x_q : lw_q;
    assign meas_h = y_q + {15'd0, line_de_q};

    // Only lines that carried DE advance the line index.
    always_ff @(posedge CLK) begin
        if (RST || fs) begin
            x_q       <= 16'd0;
            y_q       <= 16'd0;
            lw_q      <= 16'd0;
            line_de_q <= 1'b0;
        end else if (ls) begin
            x_q       <= DE ? 16'd1 : 16'd0;
            line_de_q <= DE;
            if (line_de_q) begin
                y_q  <= y_q + 16'd1;
                lw_q <= x_q;
            end
        end else if (DE) begin
            x_q       <= x_q + 16'd1;
            line_de_q <= 1'b1;
        end
    end

    assign x_end    = {1'b0, x0_q} + {1'b0, w_q};
    assign y_end    = {1'b0, y0_q} + {1'b0, h_q};
    assign in_d     = DE & valid_q & (x_cur >= x0_q) & ({1'b0, x_cur} < x_end)
                      & (y_cur >= y0_q) & ({1'b0, y_cur} < y_end);
    assign border_d = in_d & ((x_cur == x0_q) | ({1'b0, x_cur} == x_end - 17'd1)
                      | (y_cur == y0_q) | ({1'b0, y_cur} == y_end - 17'd1));

    assign init_w = (INIT_W < meas_w) ? INIT_W : meas_w;
    assign init_h = (INIT_H < meas_h) ? INIT_H : meas_h;
    assign gw     = size_grow(w_q, frm_w_q);
    assign gh     = size_grow(h_q, frm_h_q);
    assign sw     = size_shrink(w_q);
    assign sh     = size_shrink(h_q);
    assign ready  = (state_q == StRun) & ~pend_q;
    assign accept = cmd.CMD_VALID & ready;

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        frm_w_d = frm_w_q;
        frm_h_d = frm_h_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        px0_d   = px0_q;
        py0_d   = py0_q;
        pw_d    = pw_q;
        ph_d    = ph_q;
        fcnt_d  = fcnt_q;
        req_d   = req_q;
        ovf_d   = ovf_q;

        if (accept) begin
            pend_d = 1'b1;
            px0_d  = x0_q;
            py0_d  = y0_q;
            pw_d   = w_q;
            ph_d   = h_q;
            case (cmd.CMD_OP)
                3'd0: py0_d = pos_dec(y0_q);
                3'd1: py0_d = pos_inc(y0_q, h_q, frm_h_q);
                3'd2: px0_d = pos_dec(x0_q);
                3'd3: px0_d = pos_inc(x0_q, w_q, frm_w_q);
                3'd4: begin
                    pw_d  = gw;
                    ph_d  = gh;
                    px0_d = pos_fit(x0_q, gw, frm_w_q);
                    py0_d = pos_fit(y0_q, gh, frm_h_q);
                end
                3'd5: begin
                    pw_d  = sw;
                    ph_d  = sh;
                    px0_d = x0_q + ((w_q - sw) >> 1);
                    py0_d = y0_q + ((h_q - sh) >> 1);
                end
                3'd6: begin
                    px0_d = (frm_w_q - w_q) >> 1;
                    py0_d = (frm_h_q - h_q) >> 1;
                end
                default: ;
            endcase
        end

        if (req_q && cmd.STAT_ACK) begin
            req_d = 1'b0;
        end

        case (state_q)
            StInit: if (fs) state_d = StMeas;
            StMeas: begin
                if (fs) begin
                    frm_w_d = meas_w;
                    frm_h_d = meas_h;
                    w_d     = init_w;
                    h_d     = init_h;
                    x0_d    = (meas_w - init_w) >> 1;
                    y0_d    = (meas_h - init_h) >> 1;
                    valid_d = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (fs) begin
                    frm_w_d = meas_w;
                    frm_h_d = meas_h;
                    if (meas_w != frm_w_q || meas_h != frm_h_q) begin
                        valid_d = 1'b0;
                        pend_d  = 1'b0;
                        state_d = StMeas;
                    end else if (pend_q) begin
                        x0_d   = px0_q;
                        y0_d   = py0_q;
                        w_d    = pw_q;
                        h_d    = ph_q;
                        pend_d = 1'b0;
                    end
                    if ({1'b0, fcnt_q} + 9'd1 == {1'b0, STAT_DIV}) begin
                        fcnt_d = 8'd0;
                        if (req_q && !cmd.STAT_ACK) ovf_d = 1'b1;
                        req_d = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StInit;
            x0_q     <= 16'd0;
            y0_q     <= 16'd0;
            w_q      <= 16'd0;
            h_q      <= 16'd0;
            frm_w_q  <= 16'd0;
            frm_h_q  <= 16'd0;
            valid_q  <= 1'b0;
            pend_q   <= 1'b0;
            px0_q    <= 16'd0;
            py0_q    <= 16'd0;
            pw_q     <= 16'd0;
            ph_q     <= 16'd0;
            fcnt_q   <= 8'd0;
            req_q    <= 1'b0;
            ovf_q    <= 1'b0;
            in_q     <= 1'b0;
            border_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            frm_w_q  <= frm_w_d;
            frm_h_q  <= frm_h_d;
            valid_q  <= valid_d;
            pend_q   <= pend_d;
            px0_q    <= px0_d;
            py0_q    <= py0_d;
            pw_q     <= pw_d;
            ph_q     <= ph_d;
            fcnt_q   <= fcnt_d;
            req_q    <= req_d;
            ovf_q    <= ovf_d;
            in_q     <= in_d;
            border_q <= border_d;
        end
    end

    assign WIN_X0        = x0_q;
    assign WIN_Y0        = y0_q;
    assign WIN_W         = w_q;
    assign WIN_H         = h_q;
    assign FRM_W         = frm_w_q;
    assign FRM_H         = frm_h_q;
    assign WIN_VALID     = valid_q;
    assign IN_WIN        = in_q;
    assign BORDER        = border_q;
    assign cmd.CMD_READY = ready;
    assign cmd.STAT_REQ  = req_q;
    assign cmd.STAT_OVF  = ovf_q;
endmodule

// File: tb/tb_roi_window_ctrl.sv
// Directed bench for roi_window_ctrl on a scaled-down 40x10 frame (STEP 4, MIN 4, INIT 16x4).
module tb_roi_window_ctrl;
    logic CLK = 1'b0;
    logic RST, VS, HS, DE;
    logic [15:0] WIN_X0, WIN_Y0, WIN_W, WIN_H, FRM_W, FRM_H;
    logic WIN_VALID, IN_WIN, BORDER;
    int total = 0;
    int bad   = 0;
    int ex_x0, ex_y0, ex_w, ex_h;
    bit ex_valid;

    roi_window_ctrl_if bus ();

    roi_window_ctrl #(
        .STEP    (16'd4),
        .MIN_SIZE(16'd4),
        .INIT_W  (16'd16),
        .INIT_H  (16'd4),
        .STAT_DIV(8'd4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .VS       (VS),
        .HS       (HS),
        .DE       (DE),
        .cmd      (bus),
        .WIN_X0   (WIN_X0),
        .WIN_Y0   (WIN_Y0),
        .WIN_W    (WIN_W),
        .WIN_H    (WIN_H),
        .FRM_W    (FRM_W),
        .FRM_H    (FRM_H),
        .WIN_VALID(WIN_VALID),
        .IN_WIN   (IN_WIN),
        .BORDER   (BORDER)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of video; optionally check the registered flags for that pixel.
    task automatic tick(input logic vs, input logic hs, input logic de, input int x, input int y,
                        input bit chk);
        bit e_in, e_b;
        VS = vs;
        HS = hs;
        DE = de;
        @(negedge CLK);
        if (chk) begin
            e_in = de && ex_valid && x >= ex_x0 && x < ex_x0 + ex_w && y >= ex_y0
                   && y < ex_y0 + ex_h;
            e_b  = e_in && (x == ex_x0 || x == ex_x0 + ex_w - 1 || y == ex_y0
                   || y == ex_y0 + ex_h - 1);
            total++;
            if ({IN_WIN, BORDER} !== {e_in, e_b}) begin
                $display("FAIL pixel x=%0d y=%0d: in,border=%b%b want %b%b", x, y, IN_WIN,
                         BORDER, e_in, e_b);
                bad++;
            end
        end
    endtask

    task automatic run_frame(input int w, input int h, input bit chk, input bit fs_cmd,
                             input logic [2:0] op);
        bus.CMD_VALID = fs_cmd;
        bus.CMD_OP    = op;
        tick(1, 0, 0, 0, 0, chk);
        bus.CMD_VALID = 1'b0;
        tick(1, 0, 0, 0, 0, chk);
        for (int y = 0; y < h; y++) begin
            tick(1, 1, 0, 0, y, chk);
            for (int x = 0; x < w; x++) tick(1, 0, 1, x, y, chk);
            tick(1, 0, 0, 0, y, chk);
        end
        repeat (3) tick(0, 0, 0, 0, 0, chk);
    endtask

    // Offer a command during blanking; READY must then stay low until the next FS.
    task automatic send_cmd(input logic [2:0] op);
        int n = 0;
        while (bus.CMD_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (bus.CMD_READY !== 1'b1) begin
            $display("FAIL cmd_ready_wait op=%0d: ready=%b want 1", op, bus.CMD_READY);
            bad++;
        end
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = op;
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if (bus.CMD_READY !== 1'b0) begin
            $display("FAIL cmd_ready_held op=%0d: ready=%b want 0", op, bus.CMD_READY);
            bad++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        VS = 1'b0;
        HS = 1'b0;
        DE = 1'b0;
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = 3'd7;
        bus.STAT_ACK  = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if ({WIN_X0, WIN_Y0, WIN_W, WIN_H, FRM_W, FRM_H, WIN_VALID, IN_WIN, BORDER,
             bus.CMD_READY, bus.STAT_REQ, bus.STAT_OVF} !== 102'd0) begin
            $display("FAIL reset_outputs: win=%0d,%0d,%0d,%0d frm=%0d,%0d flags=%b%b%b%b%b%b want 0",
                     WIN_X0, WIN_Y0, WIN_W, WIN_H, FRM_W, FRM_H, WIN_VALID, IN_WIN, BORDER,
                     bus.CMD_READY, bus.STAT_REQ, bus.STAT_OVF);
            bad++;
        end
    endtask

    task automatic test_measure();
        run_frame(40, 10, 0, 0, 3'd7);
        total++;
        if ({WIN_VALID, bus.CMD_READY} !== 2'b00) begin
            $display("FAIL meas_first_fs: valid,ready=%b%b want 00", WIN_VALID, bus.CMD_READY);
            bad++;
        end
        run_frame(40, 10, 0, 0, 3'd7);
        total++;
        if ({FRM_W, FRM_H} !== {16'd40, 16'd10}) begin
            $display("FAIL meas_frame: %0dx%0d want 40x10", FRM_W, FRM_H);
            bad++;
        end
        total++;
        if ({WIN_X0, WIN_Y0, WIN_W, WIN_H, WIN_VALID, bus.CMD_READY}
            !== {16'd12, 16'd3, 16'd16, 16'd4, 2'b11}) begin
            $display("FAIL meas_window: x0=%0d y0=%0d w=%0d h=%0d v=%b r=%b want 12 3 16 4 1 1",
                     WIN_X0, WIN_Y0, WIN_W, WIN_H, WIN_VALID, bus.CMD_READY);
            bad++;
        end
    endtask

    task automatic test_stat();
        for (int i = 1; i <= 8; i++) begin
            run_frame(40, 10, 0, 0, 3'd7);
            total++;
            if ({bus.STAT_REQ, bus.STAT_OVF} !== {i >= 4, i >= 8}) begin
                $display("FAIL stat_sched fs=%0d: req,ovf=%b%b want %b%b", i, bus.STAT_REQ,
                         bus.STAT_OVF, i >= 4, i >= 8);
                bad++;
            end
        end
        bus.STAT_ACK = 1'b1;
        @(negedge CLK);
        bus.STAT_ACK = 1'b0;
        total++;
        if ({bus.STAT_REQ, bus.STAT_OVF} !== 2'b01) begin
            $display("FAIL stat_ack: req,ovf=%b%b want 01", bus.STAT_REQ, bus.STAT_OVF);
            bad++;
        end
        bus.STAT_ACK = 1'b1;
        @(negedge CLK);
        bus.STAT_ACK = 1'b0;
        @(negedge CLK);
        total++;
        if ({bus.STAT_REQ, bus.STAT_OVF} !== 2'b01) begin
            $display("FAIL stat_ack_idle: req,ovf=%b%b want 01", bus.STAT_REQ, bus.STAT_OVF);
            bad++;
        end
    endtask

    task automatic test_left();
        int exp_x0[5] = '{8, 4, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            send_cmd(3'd2);
            total++;
            if (WIN_X0 !== 16'd12 - 16'(i * 4) && i < 3) begin
                $display("FAIL left_before_fs %0d: x0=%0d changed early", i, WIN_X0);
                bad++;
            end
            run_frame(40, 10, 0, 0, 3'd7);
            total++;
            if ({WIN_X0, WIN_Y0, WIN_W, WIN_H, bus.CMD_READY}
                !== {16'(exp_x0[i]), 16'd3, 16'd16, 16'd4, 1'b1}) begin
                $display("FAIL left %0d: x0=%0d y0=%0d w=%0d h=%0d r=%b want x0=%0d 3 16 4 1",
                         i, WIN_X0, WIN_Y0, WIN_W, WIN_H, bus.CMD_READY, exp_x0[i]);
                bad++;
            end
        end
    endtask

    task automatic test_ops(input string name, input int n, input logic [2:0] ops[6],
                            input int ex0[6], input int ey0[6], input int ew[6], input int eh[6]);
        for (int i = 0; i < n; i++) begin
            send_cmd(ops[i]);
            run_frame(40, 10, 0, 0, 3'd7);
            total++;
            if ({WIN_X0, WIN_Y0, WIN_W, WIN_H}
                !== {16'(ex0[i]), 16'(ey0[i]), 16'(ew[i]), 16'(eh[i])}) begin
                $display("FAIL %s %0d op=%0d: x0=%0d y0=%0d w=%0d h=%0d want %0d %0d %0d %0d",
                         name, i, ops[i], WIN_X0, WIN_Y0, WIN_W, WIN_H, ex0[i], ey0[i], ew[i],
                         eh[i]);
                bad++;
            end
        end
    endtask

    task automatic test_border();
        ex_x0 = 18;
        ex_y0 = 3;
        ex_w = 4;
        ex_h = 4;
        ex_valid = 1'b1;
        run_frame(40, 10, 1, 0, 3'd7);
    endtask

    task automatic test_fs_accept();
        run_frame(40, 10, 0, 1, 3'd2);
        total++;
        if ({WIN_X0, bus.CMD_READY} !== {16'd18, 1'b0}) begin
            $display("FAIL fs_accept_pending: x0=%0d r=%b want 18 0", WIN_X0, bus.CMD_READY);
            bad++;
        end
        run_frame(40, 10, 0, 0, 3'd7);
        total++;
        if ({WIN_X0, bus.CMD_READY} !== {16'd14, 1'b1}) begin
            $display("FAIL fs_accept_commit: x0=%0d r=%b want 14 1", WIN_X0, bus.CMD_READY);
            bad++;
        end
    endtask

    task automatic test_resize();
        run_frame(32, 10, 0, 0, 3'd7);
        send_cmd(3'd2);
        ex_valid = 1'b0;
        run_frame(32, 10, 1, 0, 3'd7);
        total++;
        if ({WIN_VALID, bus.CMD_READY, FRM_W, FRM_H} !== {2'b00, 16'd32, 16'd10}) begin
            $display("FAIL resize_drop: v=%b r=%b frm=%0dx%0d want 0 0 32x10", WIN_VALID,
                     bus.CMD_READY, FRM_W, FRM_H);
            bad++;
        end
        ex_x0 = 8;
        ex_y0 = 3;
        ex_w = 16;
        ex_h = 4;
        ex_valid = 1'b1;
        run_frame(32, 10, 1, 0, 3'd7);
        total++;
        if ({WIN_X0, WIN_Y0, WIN_W, WIN_H, WIN_VALID, bus.CMD_READY}
            !== {16'd8, 16'd3, 16'd16, 16'd4, 2'b11}) begin
            $display("FAIL resize_recentre: x0=%0d y0=%0d w=%0d h=%0d v=%b r=%b want 8 3 16 4 1 1",
                     WIN_X0, WIN_Y0, WIN_W, WIN_H, WIN_VALID, bus.CMD_READY);
            bad++;
        end
    endtask

    task automatic test_rst_mid();
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        for (int x = 0; x < 10; x++) tick(1, 0, 1, x, 0, 0);
        RST = 1'b1;
        tick(1, 0, 1, 10, 0, 0);
        total++;
        if ({WIN_X0, WIN_Y0, WIN_W, WIN_H, FRM_W, FRM_H, WIN_VALID, IN_WIN, BORDER,
             bus.CMD_READY, bus.STAT_REQ, bus.STAT_OVF} !== 102'd0) begin
            $display("FAIL rst_mid_outputs: win=%0d,%0d,%0d,%0d frm=%0d,%0d flags=%b%b%b%b%b%b want 0",
                     WIN_X0, WIN_Y0, WIN_W, WIN_H, FRM_W, FRM_H, WIN_VALID, IN_WIN, BORDER,
                     bus.CMD_READY, bus.STAT_REQ, bus.STAT_OVF);
            bad++;
        end
        RST = 1'b0;
        for (int x = 11; x < 32; x++) tick(1, 0, 1, x, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0, 0);
        run_frame(32, 10, 0, 0, 3'd7);
        total++;
        if (WIN_VALID !== 1'b0) begin
            $display("FAIL rst_mid_meas: valid=%b want 0", WIN_VALID);
            bad++;
        end
        run_frame(32, 10, 0, 0, 3'd7);
        total++;
        if ({WIN_X0, WIN_Y0, WIN_W, WIN_H, FRM_W, FRM_H, WIN_VALID, bus.STAT_OVF}
            !== {16'd8, 16'd3, 16'd16, 16'd4, 16'd32, 16'd10, 2'b10}) begin
            $display("FAIL rst_mid_run: x0=%0d y0=%0d w=%0d h=%0d frm=%0dx%0d v=%b ovf=%b",
                     WIN_X0, WIN_Y0, WIN_W, WIN_H, FRM_W, FRM_H, WIN_VALID, bus.STAT_OVF);
            bad++;
        end
    endtask

    initial begin
        logic [2:0] ops[6];
        int ex0[6], ey0[6], ew[6], eh[6];
        test_reset();
        test_measure();
        test_stat();
        test_left();
        ops = '{3'd4, 3'd4, 3'd3, 3'd4, 3'd7, 3'd7};
        ex0 = '{0, 0, 4, 0, 0, 0};
        ey0 = '{0, 0, 0, 0, 0, 0};
        ew  = '{24, 32, 32, 40, 40, 40};
        eh  = '{10, 10, 10, 10, 10, 10};
        test_ops("grow", 4, ops, ex0, ey0, ew, eh);
        ops = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
        ex0 = '{4, 8, 12, 16, 18, 18};
        ey0 = '{3, 3, 3, 3, 3, 3};
        ew  = '{32, 24, 16, 8, 4, 4};
        eh  = '{4, 4, 4, 4, 4, 4};
        test_ops("shrink", 6, ops, ex0, ey0, ew, eh);
        test_border();
        ops = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd6, 3'd7};
        ex0 = '{18, 18, 18, 14, 18, 18};
        ey0 = '{0, 4, 6, 6, 3, 3};
        ew  = '{4, 4, 4, 4, 4, 4};
        eh  = '{4, 4, 4, 4, 4, 4};
        test_ops("updown", 6, ops, ex0, ey0, ew, eh);
        test_fs_accept();
        test_resize();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
